video_dram_arb: RTL and testbench
=================================

// Module: video_dram_arb
// PURPOSE
//  Slot arbiter between the video fetch port and the CPU port for the shared DRAM.
//  At each DRAM slot start it grants the slot to video, to the CPU, or to nobody,
//  following the requested video bandwidth. It returns read data as video_strobe/video_data.
//  Sits directly upstream of video_top: drives its video_next/video_strobe/video_data inputs.
// PARAMETERS
//  AW  21  DRAM word address width
//  DW  16  DRAM data width
// PORTS
//  clk           in   1   28 MHz system clock
//  rst           in   1   asynchronous, active-high reset
//  cycle_beg     in   1   1-clk pulse from DRAM controller: start of a DRAM slot
//  video_go      in   1   video fetch window active (level)
//  video_bw      in   2   00=1/8, 01=1/4, 10=1/2, 11=every slot
//  video_addr    in   AW  video word address
//  video_next    out  1   1-clk pulse: video owns this slot, video_addr consumed
//  video_strobe  out  1   1-clk pulse: video_data valid
//  video_data    out  DW  registered video read data
//  cpu_req       in   1   CPU access request (level, held until cpu_next)
//  cpu_rnw       in   1   1=read, 0=write
//  cpu_addr      in   AW  CPU word address
//  cpu_wdata     in   DW  CPU write data
//  cpu_next      out  1   1-clk pulse: CPU request accepted for this slot
//  cpu_strobe    out  1   1-clk pulse: CPU read data valid (reads only)
//  cpu_rdata     out  DW  registered CPU read data
//  dram_req      out  1   slot in use (registered, held for the whole slot)
//  dram_rnw      out  1   direction for current slot (video always 1)
//  dram_addr     out  AW  address for current slot
//  dram_wdata    out  DW  write data for current slot
//  dram_rdata    in   DW  DRAM read data
//  dram_rdone    in   1   1-clk pulse: dram_rdata valid for current slot
// BEHAVIOUR
//  - Reset: all outputs 0, slot counter 0, owner=NONE; an in-flight slot is abandoned.
//  - Slot counter sc[2:0]:
//    - cleared while video_go=0.
//    - increments on each cycle_beg while video_go=1, wrapping 7->0.
//  - Video owns a slot when cycle_beg & video_go and:
//    - bw=00: sc==0
//    - bw=01: sc[1:0]==0
//    - bw=10: sc[0]==0
//    - bw=11: always
//    - sc is sampled before the increment, so the first slot after video_go rises is video's.
//  - Otherwise, if cpu_req=1, the CPU owns the slot; else owner=NONE and dram_req=0.
//  - Owner register: NONE/VID/CPU, updated only on cycle_beg. It selects the
//    dram_req/rnw/addr/wdata registers, which are loaded in that same clk.
//  - video_next / cpu_next: asserted the clk after the cycle_beg that granted the slot.
//    Exactly one pulse per granted slot.
//  - Read completion: on dram_rdone with owner=VID, or owner=CPU & rnw=1:
//    - latch dram_rdata into video_data or cpu_rdata;
//    - pulse video_strobe or cpu_strobe one clk later (latency 1).
//  - dram_rdone with owner=NONE, or on a CPU write slot: ignored, no strobe.
//  - dram_rdone and cycle_beg in the same clk: rdone belongs to the ending slot
//    (old owner); the new owner is applied after.
//  - Missing dram_rdone before the next cycle_beg: no strobe for that slot, no error state.
//  - A second dram_rdone within one slot is ignored (per-slot done flag).
//  - video_go falling mid-slot: the current slot completes normally (strobe still issued).
//    The next slot is arbitrated with video_go=0.
//  - video_bw changing mid-window: takes effect at the next cycle_beg; sc is not cleared.
//  - cpu_req held across video slots: the CPU waits; no starvation bound for bw=11 (by design).
// TESTING
//  1. Reset mid-slot (owner=VID, rdone pending) -> all outputs 0 next clk, no video_strobe after release.
//  2. video_go=1, bw=01, cpu_req=1, 8 slots -> video_next on slots 0,4; cpu_next on slots 1-3,5-7.
//  3. bw=00, video_addr=21'h1ABCD, dram_rdata=16'hBEEF rdone -> dram_addr=21'h1ABCD, dram_rnw=1;
//     video_data=16'hBEEF with video_strobe exactly 1 clk after rdone.
//  4. CPU write cpu_addr=21'h00100, wdata=16'h55AA in free slot -> dram_rnw=0, dram_wdata=16'h55AA;
//     one cpu_next pulse, no cpu_strobe.
//  5. rdone coincident with cycle_beg at video->CPU slot boundary -> video_strobe fires; cpu_next fires; no cpu_strobe.
//  6. video_go=0, cpu_req=0 for 4 slots -> dram_req=0 throughout, sc stays 0; video_go rise -> first slot is video.

Source files
------------

// File: rtl/video_dram_arb.sv
// Shared-DRAM slot arbiter: grants each DRAM slot to video, CPU or nobody
// according to the requested video bandwidth, and returns read data to the slot owner.
module video_dram_arb #(
  parameter int AW = 21,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cycle_beg,
  input  logic          video_go,
  input  logic [1:0]    video_bw,
  input  logic [AW-1:0] video_addr,
  output logic          video_next,
  output logic          video_strobe,
  output logic [DW-1:0] video_data,
  input  logic          cpu_req,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_next,
  output logic          cpu_strobe,
  output logic [DW-1:0] cpu_rdata,
  output logic          dram_req,
  output logic          dram_rnw,
  output logic [AW-1:0] dram_addr,
  output logic [DW-1:0] dram_wdata,
  input  logic [DW-1:0] dram_rdata,
  input  logic          dram_rdone
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  owner_t        r_owner;
  owner_t        w_owner_nxt;
  logic [2:0]    r_sc;
  logic          r_done;
  logic          w_bw_hit;
  logic          w_vid_grant;
  logic          w_rd_vid;
  logic          w_rd_cpu;

  logic          r_video_next;
  logic          r_video_strobe;
  logic [DW-1:0] r_video_data;
  logic          r_cpu_next;
  logic          r_cpu_strobe;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_dram_req;
  logic          r_dram_rnw;
  logic [AW-1:0] r_dram_addr;
  logic [DW-1:0] r_dram_wdata;

  // The slot counter is sampled before it advances, so slot 0 of a window is video's.
  always_comb begin
    w_bw_hit = 1'b1;
    unique case (video_bw)
      2'b00:   w_bw_hit = (r_sc == 3'd0);
      2'b01:   w_bw_hit = (r_sc[1:0] == 2'd0);
      2'b10:   w_bw_hit = ~r_sc[0];
      default: w_bw_hit = 1'b1;
    endcase
    w_vid_grant = video_go & w_bw_hit;
  end

  always_comb begin
    w_owner_nxt = r_owner;
    if (cycle_beg) begin
      if (w_vid_grant)  w_owner_nxt = OWN_VID;
      else if (cpu_req) w_owner_nxt = OWN_CPU;
      else              w_owner_nxt = OWN_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_owner <= OWN_NONE;
    else     r_owner <= w_owner_nxt;
  end

  // Completion is judged against the slot that is ending, even when a new one starts this clk.
  assign w_rd_vid = dram_rdone & ~r_done & (r_owner == OWN_VID);
  assign w_rd_cpu = dram_rdone & ~r_done & (r_owner == OWN_CPU) & r_dram_rnw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc           <= 3'd0;
      r_done         <= 1'b0;
      r_video_next   <= 1'b0;
      r_video_strobe <= 1'b0;
      r_video_data   <= '0;
      r_cpu_next     <= 1'b0;
      r_cpu_strobe   <= 1'b0;
      r_cpu_rdata    <= '0;
      r_dram_req     <= 1'b0;
      r_dram_rnw     <= 1'b0;
      r_dram_addr    <= '0;
      r_dram_wdata   <= '0;
    end else begin
      r_video_next   <= cycle_beg & w_vid_grant;
      r_cpu_next     <= cycle_beg & ~w_vid_grant & cpu_req;
      r_video_strobe <= w_rd_vid;
      r_cpu_strobe   <= w_rd_cpu;
      if (w_rd_vid) r_video_data <= dram_rdata;
      if (w_rd_cpu) r_cpu_rdata  <= dram_rdata;

      if (cycle_beg)       r_done <= 1'b0;
      else if (dram_rdone) r_done <= 1'b1;

      if (!video_go)      r_sc <= 3'd0;
      else if (cycle_beg) r_sc <= r_sc + 3'd1;

      if (cycle_beg) begin
        unique case (w_owner_nxt)
          OWN_VID: begin
            r_dram_req   <= 1'b1;
            r_dram_rnw   <= 1'b1;
            r_dram_addr  <= video_addr;
            r_dram_wdata <= '0;
          end
          OWN_CPU: begin
            r_dram_req   <= 1'b1;
            r_dram_rnw   <= cpu_rnw;
            r_dram_addr  <= cpu_addr;
            r_dram_wdata <= cpu_wdata;
          end
          default: begin
            r_dram_req   <= 1'b0;
            r_dram_rnw   <= 1'b0;
            r_dram_addr  <= '0;
            r_dram_wdata <= '0;
          end
        endcase
      end
    end
  end

  assign video_next   = r_video_next;
  assign video_strobe = r_video_strobe;
  assign video_data   = r_video_data;
  assign cpu_next     = r_cpu_next;
  assign cpu_strobe   = r_cpu_strobe;
  assign cpu_rdata    = r_cpu_rdata;
  assign dram_req     = r_dram_req;
  assign dram_rnw     = r_dram_rnw;
  assign dram_addr    = r_dram_addr;
  assign dram_wdata   = r_dram_wdata;

endmodule

// File: tb/tb_video_dram_arb.sv
// Bench for video_dram_arb: directed slot scenarios followed by randomized slots,
// all checked every clk against a slot-level reference model.
module tb_video_dram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cycle_beg = 1'b0;
  logic        video_go = 1'b0;
  logic [1:0]  video_bw = 2'b00;
  logic [20:0] video_addr = '0;
  logic        video_next, video_strobe;
  logic [15:0] video_data;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b0;
  logic [20:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_next, cpu_strobe;
  logic [15:0] cpu_rdata;
  logic        dram_req, dram_rnw;
  logic [20:0] dram_addr;
  logic [15:0] dram_wdata;
  logic [15:0] dram_rdata = '0;
  logic        dram_rdone = 1'b0;

  always #5 clk = ~clk;

  video_dram_arb #(.AW(21), .DW(16)) dut (
    .clk(clk), .rst(rst), .cycle_beg(cycle_beg),
    .video_go(video_go), .video_bw(video_bw), .video_addr(video_addr),
    .video_next(video_next), .video_strobe(video_strobe), .video_data(video_data),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_rdata(cpu_rdata),
    .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .dram_rdone(dram_rdone)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one record for the slot in progress plus the expected output pulses.
  localparam int OWN_NONE = 0, OWN_VID = 1, OWN_CPU = 2;
  int          m_sc, m_owner;
  bit          m_done, m_req, m_rnw;
  logic [20:0] m_addr;
  logic [15:0] m_wdata, e_vdata, e_cdata;
  bit          e_vnext, e_cnext, e_vstb, e_cstb;
  int          n_vnext, n_cnext, n_vstb, n_cstb;
  bit          cpu_hold = 0;
  bit          cpu_auto = 0;

  task automatic model_reset();
    m_sc = 0; m_owner = OWN_NONE; m_done = 0; m_req = 0; m_rnw = 0;
    m_addr = '0; m_wdata = '0; e_vdata = '0; e_cdata = '0;
    e_vnext = 0; e_cnext = 0; e_vstb = 0; e_cstb = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    e_vnext = 0; e_cnext = 0; e_vstb = 0; e_cstb = 0;
    if (dram_rdone && !m_done) begin
      if (m_owner == OWN_VID) begin
        e_vstb = 1; e_vdata = dram_rdata;
      end else if (m_owner == OWN_CPU && m_rnw) begin
        e_cstb = 1; e_cdata = dram_rdata;
      end
    end
    if (dram_rdone) m_done = 1;
    if (cycle_beg) begin
      m_done = 0;
      // Video gets one slot in every (8 >> bw) counted slots, starting at slot 0.
      if (video_go && (m_sc % (8 >> video_bw)) == 0) begin
        m_owner = OWN_VID; m_req = 1; m_rnw = 1; m_addr = video_addr; m_wdata = '0;
        e_vnext = 1;
      end else if (cpu_req) begin
        m_owner = OWN_CPU; m_req = 1; m_rnw = cpu_rnw; m_addr = cpu_addr; m_wdata = cpu_wdata;
        e_cnext = 1;
      end else begin
        m_owner = OWN_NONE; m_req = 0;
      end
    end
    if (!video_go)      m_sc = 0;
    else if (cycle_beg) m_sc = (m_sc + 1) % 8;
  endtask

  task automatic compare_all();
    check("dram_req", dram_req, m_req);
    if (m_req) begin
      check("dram_rnw", dram_rnw, m_rnw);
      check("dram_addr", dram_addr, m_addr);
      if (!m_rnw) check("dram_wdata", dram_wdata, m_wdata);
    end
    check("video_next", video_next, e_vnext);
    check("cpu_next", cpu_next, e_cnext);
    check("video_strobe", video_strobe, e_vstb);
    check("cpu_strobe", cpu_strobe, e_cstb);
    check("video_data", video_data, e_vdata);
    check("cpu_rdata", cpu_rdata, e_cdata);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    n_vnext += int'(video_next);
    n_cnext += int'(cpu_next);
    n_vstb  += int'(video_strobe);
    n_cstb  += int'(cpu_strobe);
  endtask

  task automatic new_cpu_req();
    cpu_req = 1; cpu_rnw = 1'($urandom);
    cpu_addr = 21'($urandom); cpu_wdata = 16'($urandom);
  endtask

  task automatic cyc(input bit cb, input bit rd, input logic [15:0] rdata);
    cycle_beg = cb; dram_rdone = rd;
    dram_rdata = rd ? rdata : 16'($urandom);
    tick();
    cycle_beg = 0; dram_rdone = 0;
    if (e_cnext) begin
      if (cpu_hold) new_cpu_req();
      else cpu_req = 0;
    end
    if (cpu_auto && !cpu_req && $urandom_range(0, 2) == 0) new_cpu_req();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_dram_req", dram_req, 0);
    check("rst_dram_addr", dram_addr, 0);
    check("rst_video_next", video_next, 0);
    check("rst_video_strobe", video_strobe, 0);
    check("rst_video_data", video_data, 0);
    check("rst_cpu_next", cpu_next, 0);
    check("rst_cpu_strobe", cpu_strobe, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    model_reset();
    tick();
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, v0, s0;
    logic [7:0] vmask, cmask;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle: no video window, no CPU -> no slot is used.
    v0 = n_vnext; c0 = n_cnext;
    for (int s = 0; s < 4; s++) begin
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    end
    check("idle_vnext_cnt", n_vnext - v0, 0);
    check("idle_cnext_cnt", n_cnext - c0, 0);

    // Window opens at bw=1/8: first slot is video, read returns one clk after rdone.
    video_go = 1; video_bw = 2'b00; video_addr = 21'h1ABCD;
    cyc(1, 0, 0);
    check("vid_first_next", video_next, 1);
    check("vid_addr", dram_addr, 21'h1ABCD);
    check("vid_rnw", dram_rnw, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 16'hBEEF);
    check("vid_strobe", video_strobe, 1);
    check("vid_data", video_data, 16'hBEEF);
    cyc(0, 0, 0);
    check("vid_strobe_once", video_strobe, 0);

    // CPU write in a free slot: one accept pulse, no read strobe.
    c0 = n_cnext; s0 = n_cstb;
    cpu_req = 1; cpu_rnw = 0; cpu_addr = 21'h00100; cpu_wdata = 16'h55AA;
    cyc(1, 0, 0);
    check("wr_rnw", dram_rnw, 0);
    check("wr_wdata", dram_wdata, 16'h55AA);
    check("wr_addr", dram_addr, 21'h00100);
    cyc(0, 1, 16'h1111);
    cyc(0, 0, 0);
    check("wr_cnext_cnt", n_cnext - c0, 1);
    check("wr_cstb_cnt", n_cstb - s0, 0);

    // rdone coincident with the video->CPU slot boundary.
    video_bw = 2'b10;
    cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h0F0F0;
    cyc(1, 0, 0);
    check("bnd_vnext", video_next, 1);
    cyc(0, 0, 0);
    cyc(1, 1, 16'h1234);
    check("bnd_vstrobe", video_strobe, 1);
    check("bnd_vdata", video_data, 16'h1234);
    check("bnd_cnext", cpu_next, 1);
    check("bnd_cstrobe", cpu_strobe, 0);
    cyc(0, 1, 16'hABCD);
    check("cpu_rd_strobe", cpu_strobe, 1);
    check("cpu_rd_data", cpu_rdata, 16'hABCD);
    cyc(0, 1, 16'h5555);
    check("cpu_rd_second", cpu_strobe, 0);
    check("cpu_rd_kept", cpu_rdata, 16'hABCD);

    // bw=1/4 with a permanently requesting CPU over 8 slots.
    video_go = 0;
    cyc(0, 0, 0);
    video_go = 1; video_bw = 2'b01; cpu_hold = 1; new_cpu_req();
    vmask = '0; cmask = '0;
    for (int s = 0; s < 8; s++) begin
      cyc(1, 0, 0);
      vmask[s] = video_next;
      cmask[s] = cpu_next;
      cyc(0, 0, 0); cyc(0, 0, 0);
    end
    check("bw01_video_slots", vmask, 8'h11);
    check("bw01_cpu_slots", cmask, 8'hEE);
    cpu_hold = 0; cpu_req = 0;

    // Reset while a video read is pending: no strobe after release.
    video_bw = 2'b11;
    cyc(1, 0, 0); cyc(0, 0, 0);
    do_reset();
    cyc(0, 1, 16'hDEAD);
    check("rst_no_vstrobe", video_strobe, 0);
    cyc(0, 0, 0);

    // Randomized slots: lengths, rdone placement, window/bandwidth changes, CPU traffic.
    cpu_auto = 1;
    for (int s = 0; s < 300; s++) begin
      int len, rd_at;
      len = $urandom_range(2, 6);
      rd_at = $urandom_range(0, len);
      if ($urandom_range(0, 7) == 0) video_go = ~video_go;
      if ($urandom_range(0, 5) == 0) video_bw = 2'($urandom);
      if ($urandom_range(0, 59) == 0) do_reset();
      for (int i = 0; i < len; i++) begin
        video_addr = 21'($urandom);
        if (i > 0 && $urandom_range(0, 19) == 0) video_go = ~video_go;
        cyc(i == 0, i == rd_at || (i > rd_at && $urandom_range(0, 9) == 0), 16'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
